// File: rtl/echo_responder_if.sv
// rtl/echo_responder_if.sv - trigger/echo handshake bundle between a ranging master and the responder
interface echo_responder_if;
    logic        trig;
    logic [11:0] dist_us;
    logic        echo;
    logic        busy;
    logic        trig_short;
    logic        echo_done;

    modport master (
        output trig, dist_us,
        input  echo, busy, trig_short, echo_done
    );

    modport slave (
        input  trig, dist_us,
        output echo, busy, trig_short, echo_done
    );
endinterface

// File: rtl/echo_responder.sv
// rtl/echo_responder.sv - ultrasonic ranger emulator: qualifies a trig pulse, waits a burst delay,
// then drives an echo pulse whose width encodes the emulated distance, followed by a dead time.
module echo_responder #(
    parameter int CLK_PER_US  = 40,
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic             clk,
    input  logic             reset,
    echo_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_TRIG, ST_BURST, ST_ECHO, ST_HOLD
    } state_t;

    localparam int              PW         = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0]   PRE_MAX    = PW'(CLK_PER_US - 1);
    localparam logic [15:0]     MIN_US     = 16'(MIN_TRIG_US);
    localparam logic [15:0]     MIN_M1     = 16'(MIN_TRIG_US - 1);
    localparam logic [15:0]     BURST_M1   = 16'(BURST_US - 1);
    localparam logic [15:0]     TIMEOUT_M1 = 16'(TIMEOUT_US - 1);
    localparam logic [15:0]     HOLD_M1    = 16'(HOLDOFF_US - 1);

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          trig_s_q, trig_s_d;
    logic [1:0]    sync_vld_q, sync_vld_d;
    logic          trig_low_q, trig_low_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [15:0]   us_q, us_d;
    logic [11:0]   dist_q, dist_d;
    logic          echo_q, echo_d;
    logic          trig_short_q, trig_short_d;
    logic          echo_done_q, echo_done_d;

    logic          us_wrap;
    logic          trig_ok;
    logic [15:0]   echo_m1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b0;
            trig_s_q     <= 1'b0;
            sync_vld_q   <= 2'b00;
            trig_low_q   <= 1'b0;
            pre_q        <= '0;
            us_q         <= '0;
            dist_q       <= '0;
            echo_q       <= 1'b0;
            trig_short_q <= 1'b0;
            echo_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            trig_s_q     <= trig_s_d;
            sync_vld_q   <= sync_vld_d;
            trig_low_q   <= trig_low_d;
            pre_q        <= pre_d;
            us_q         <= us_d;
            dist_q       <= dist_d;
            echo_q       <= echo_d;
            trig_short_q <= trig_short_d;
            echo_done_q  <= echo_done_d;
        end
    end

    // trig_low only counts once the synchronizer holds a real sample, so a trig
    // already high when reset releases never looks like a rising edge.
    always_comb begin
        sync1_d    = bus.trig;
        trig_s_d   = sync1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        trig_low_d = sync_vld_q[1] & ~trig_s_q;
    end

    // Elapsed time in the current state is us_q*CLK_PER_US + pre_q cycles; a phase of
    // T us ends on the edge closing its last cycle, i.e. us_q == T-1 at a prescaler wrap.
    assign us_wrap = (pre_q == PRE_MAX);
    assign trig_ok = (us_q >= MIN_US) || ((us_q == MIN_M1) && us_wrap);
    assign echo_m1 = (dist_q == 12'd0) ? TIMEOUT_M1 : (16'(dist_q) - 16'd1);

    always_comb begin
        state_d = state_q;
        dist_d  = dist_q;
        case (state_q)
            ST_IDLE:  if (trig_s_q && trig_low_q) state_d = ST_TRIG;
            ST_TRIG:  if (!trig_s_q) begin
                          if (trig_ok) begin
                              state_d = ST_BURST;
                              dist_d  = bus.dist_us;
                          end else begin
                              state_d = ST_IDLE;
                          end
                      end
            ST_BURST: if (us_wrap && (us_q == BURST_M1)) state_d = ST_ECHO;
            ST_ECHO:  if (us_wrap && (us_q == echo_m1))  state_d = ST_HOLD;
            ST_HOLD:  if (us_wrap && (us_q == HOLD_M1))  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pre_d = pre_q;
        us_d  = us_q;
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            pre_d = '0;
            us_d  = '0;
        end else if (us_wrap) begin
            pre_d = '0;
            us_d  = (us_q == 16'hFFFF) ? us_q : us_q + 16'd1;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_comb begin
        echo_d       = (state_d == ST_ECHO);
        trig_short_d = (state_q == ST_TRIG) && (state_d == ST_IDLE);
        echo_done_d  = (state_q == ST_ECHO) && (state_d == ST_HOLD);
    end

    assign bus.echo       = echo_q;
    assign bus.trig_short = trig_short_q;
    assign bus.echo_done  = echo_done_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: doc/echo_responder.md
ECHO_RESPONDER -- requirements
Module: echo_responder

Interface
REQ-001 The block SHALL have parameter CLK_PER_US, default 40, clk cycles per microsecond.
REQ-002 The block SHALL have parameter MIN_TRIG_US, default 10, minimum accepted trig width in us.
REQ-003 The block SHALL have parameter BURST_US, default 200, trig-fall to echo-rise delay in us.
REQ-004 The block SHALL have parameter TIMEOUT_US, default 38000, echo width for "no object" (dist_us == 0).
REQ-005 The block SHALL have parameter HOLDOFF_US, default 10000, post-echo dead time in us.
REQ-006 The block SHALL have port clk, input, 1, single clock for all logic.
REQ-007 The block SHALL have port reset, input, 1, asynchronous, active-low (0 = in reset).
REQ-008 The block SHALL have port trig, input, 1, asynchronous trigger from the ranging master.
REQ-009 The block SHALL have port dist_us, input, 12, emulated round-trip echo width in us.
REQ-010 The block SHALL have port echo, output, 1, echo pulse to the ranging master.
REQ-011 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-012 The block SHALL have port trig_short, output, 1, one-cycle pulse on a rejected trig.
REQ-013 The block SHALL have port echo_done, output, 1, one-cycle pulse in the cycle echo falls.

Function
REQ-014 trig SHALL pass through a 2-flop synchronizer; all logic uses synchronized trig_s.
REQ-015 States SHALL be IDLE, TRIG, BURST, ECHO, HOLDOFF.
REQ-016 A us prescaler (0..CLK_PER_US-1) SHALL clear on every state entry; a us counter (16 bit) increments on each prescaler wrap and clears on state entry.
REQ-017 IDLE -> TRIG SHALL occur only on a trig_s rising edge (0 then 1); trig_s held high from reset or HOLDOFF SHALL NOT start a cycle.
REQ-018 In TRIG, on trig_s falling, if trig_s was high for N cycles with N >= MIN_TRIG_US*CLK_PER_US, state -> BURST and dist_us SHALL be latched in that same edge.
REQ-019 In TRIG, on trig_s falling with N < MIN_TRIG_US*CLK_PER_US, state -> IDLE and trig_short SHALL pulse for exactly one cycle.
REQ-020 Changes on dist_us after the latch edge SHALL have no effect on the current cycle.
REQ-021 echo SHALL be registered and rise exactly BURST_US*CLK_PER_US cycles after the BURST entry edge; state -> ECHO on that edge.
REQ-022 echo SHALL stay high exactly W*CLK_PER_US cycles, W = latched dist_us, or W = TIMEOUT_US if latched dist_us == 0.
REQ-023 On echo fall, echo_done SHALL pulse one cycle and state -> HOLDOFF.
REQ-024 In BURST, ECHO and HOLDOFF, trig_s activity SHALL be ignored.
REQ-025 HOLDOFF SHALL last HOLDOFF_US*CLK_PER_US cycles, then state -> IDLE.
REQ-026 busy SHALL be combinational from state; echo, trig_short, echo_done SHALL be flop outputs.
REQ-027 TRIG with trig_s high longer than 65535 us SHALL saturate the counter and still accept on fall.

Reset
REQ-028 While reset = 0: state = IDLE, echo = 0, trig_short = 0, echo_done = 0, busy = 0, counters, synchronizer and latched distance = 0.
REQ-029 Reset asserted mid-ECHO SHALL drop echo immediately (asynchronously), without an echo_done pulse.
REQ-030 After reset release, the first cycle SHALL require a fresh trig rising edge.

Verification
REQ-031 trig high 400 cycles, dist_us = 100 -> echo rises 8000 cycles after BURST entry, high exactly 4000 cycles, echo_done pulses once, busy low 400000 cycles after echo fall.
REQ-032 trig high 399 cycles -> trig_short single pulse, echo stays 0, busy returns 0.
REQ-033 dist_us = 0 -> echo high exactly 1,520,000 cycles (38000 us).
REQ-034 dist_us changed 100 -> 4095 during BURST -> echo width stays 4000 cycles.
REQ-035 trig pulses during BURST/ECHO/HOLDOFF, and trig held high into IDLE -> no new cycle until trig falls and rises again.
REQ-036 reset driven 0 midway through echo -> echo 0 same time step, no echo_done; after release, state IDLE.
